// File: rtl/dmem_req_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_req_ctrl_pkg / dmem_req_ctrl
//
// Memory-stage data-memory request controller. Takes the mem-op fields of the
// instruction in the memory stage and issues a single request to data memory.
// It collects the response over a valid/yumi handshake and stalls the pipeline
// until the access retires. Load data is returned zero-extended (byte or word).
// A hung memory is flagged through a timeout counter that parks the FSM in a
// sticky error state.
//
// Ports
//   clk           in   core clock, all state on rising edge
//   n_reset       in   asynchronous active-low reset
//   mem_op_i      in   instruction in the memory stage is a mem op
//   is_load_i     in   1 = load (LW/LBU), 0 = store (SW/SB)
//   is_byte_i     in   byte access (LBU/SB)
//   addr_i        in   effective byte address
//   store_data_i  in   store source operand
//   from_mem_i    in   memory -> controller: read_data, valid, yumi
//   to_mem_o      out  controller -> memory: write_data, valid, wen,
//                      byte_not_word, yumi
//   mem_addr_o    out  registered request address
//   load_data_o   out  load result, valid while done_o = 1
//   done_o        out  one-cycle pulse when the access retires
//   stall_o       out  hold the pipeline (combinational)
//   err_o         out  sticky timeout error
//   state_o       out  FSM state (IDLE=0, REQ_SENT=1, REQ_ACKED=2, ERR=3)
// -----------------------------------------------------------------------------
package dmem_req_ctrl_pkg;

    parameter int unsigned MEM_DATA_W = 32;

    typedef struct packed {
        logic [MEM_DATA_W-1:0] read_data;
        logic                  valid;
        logic                  yumi;
    } mem_out_s;

    typedef struct packed {
        logic [MEM_DATA_W-1:0] write_data;
        logic                  valid;
        logic                  wen;
        logic                  byte_not_word;
        logic                  yumi;
    } mem_in_s;

endpackage

module dmem_req_ctrl
    import dmem_req_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W      = MEM_DATA_W,
    parameter int unsigned TIMEOUT_MAX = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              mem_op_i,
    input  logic              is_load_i,
    input  logic              is_byte_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  mem_out_s          from_mem_i,
    output mem_in_s           to_mem_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] load_data_o,
    output logic              done_o,
    output logic              stall_o,
    output logic              err_o,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REQ_SENT  = 2'd1,
        S_REQ_ACKED = 2'd2,
        S_ERR       = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] ldata_q;
    logic              is_load_q;
    logic              is_byte_q;

    logic              accept;
    logic              capture;
    logic              complete;
    logic              waiting;
    logic [7:0]        rd_lane;

    // done_q blocks re-accepting the retiring instruction, which is still on
    // the inputs during its done cycle. n_reset is folded in so stall_o is
    // also low while reset is asserted.
    assign accept  = n_reset && (state_q == S_IDLE) && mem_op_i && !done_q;
    assign waiting = (state_q == S_REQ_SENT) || (state_q == S_REQ_ACKED);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        capture  = 1'b0;
        complete = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_REQ_SENT;
                    cnt_d   = '0;
                end
            end
            S_REQ_SENT: begin
                if (from_mem_i.yumi) begin
                    if (!is_load_q) begin
                        complete = 1'b1;
                    end else if (from_mem_i.valid) begin
                        capture  = 1'b1;
                        complete = 1'b1;
                    end else begin
                        state_d = S_REQ_ACKED;
                    end
                end
            end
            S_REQ_ACKED: begin
                if (from_mem_i.valid) begin
                    capture  = 1'b1;
                    complete = 1'b1;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Completion takes priority over the timeout in the same cycle.
        if (waiting) begin
            if (complete) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end else if (cnt_q == CNT_W'(TIMEOUT_MAX)) begin
                state_d = S_ERR;
            end
            if (cnt_q != CNT_W'(TIMEOUT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Little-endian byte lane of the returned word.
    always_comb begin
        rd_lane = from_mem_i.read_data[7:0];
        unique case (addr_q[1:0])
            2'd0: rd_lane = from_mem_i.read_data[7:0];
            2'd1: rd_lane = from_mem_i.read_data[15:8];
            2'd2: rd_lane = from_mem_i.read_data[23:16];
            2'd3: rd_lane = from_mem_i.read_data[31:24];
            default: rd_lane = from_mem_i.read_data[7:0];
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ldata_q   <= '0;
            is_load_q <= 1'b0;
            is_byte_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            if (accept) begin
                addr_q    <= addr_i;
                is_load_q <= is_load_i;
                is_byte_q <= is_byte_i;
                // Byte stores replicate the byte on every lane; memory picks
                // the lane from the address.
                wdata_q   <= is_byte_i ? {(DATA_W/8){store_data_i[7:0]}} : store_data_i;
            end
            if (capture) begin
                ldata_q <= is_byte_q ? {{(DATA_W-8){1'b0}}, rd_lane} : from_mem_i.read_data;
            end
        end
    end

    always_comb begin
        to_mem_o = '0;
        if (state_q == S_REQ_SENT) begin
            to_mem_o.valid         = 1'b1;
            to_mem_o.wen           = !is_load_q;
            to_mem_o.byte_not_word = is_byte_q;
            to_mem_o.write_data    = wdata_q;
        end
        to_mem_o.yumi = capture;
    end

    assign mem_addr_o  = addr_q;
    assign load_data_o = ldata_q;
    assign done_o      = done_q;
    assign stall_o     = accept || (state_q != S_IDLE);
    assign err_o       = (state_q == S_ERR);
    assign state_o     = state_q;

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_req_ctrl
//
// Self-checking bench for dmem_req_ctrl. Stimulus is driven 1 ns after the
// rising edge and outputs are sampled on the falling edge. Expected values
// come from a transaction-level view of the access: request cycles until the
// memory's yumi, response data formatted with plain arithmetic, and a
// timeout expressed as a count of waiting cycles.
// -----------------------------------------------------------------------------
module tb_dmem_req_ctrl;
    import dmem_req_ctrl_pkg::*;

    localparam int TMAX = 12;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        mem_op, is_load, is_byte;
    logic [31:0] addr, sdata;
    mem_out_s    fm;
    mem_in_s     tm;
    logic [31:0] maddr, ldata;
    logic        done, stall, err;
    logic [1:0]  st;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_load = '0;

    dmem_req_ctrl #(
        .DATA_W     (32),
        .TIMEOUT_MAX(TMAX),
        .CNT_W      (4)
    ) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .mem_op_i    (mem_op),
        .is_load_i   (is_load),
        .is_byte_i   (is_byte),
        .addr_i      (addr),
        .store_data_i(sdata),
        .from_mem_i  (fm),
        .to_mem_o    (tm),
        .mem_addr_o  (maddr),
        .load_data_o (ldata),
        .done_o      (done),
        .stall_o     (stall),
        .err_o       (err),
        .state_o     (st)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        n_reset = 1'b0;
        mem_op  = 1'b1;
        is_load = 1'b1;
        is_byte = 1'b0;
        addr    = 32'h40;
        sdata   = 32'h1234_5678;
        fm      = '{read_data: 32'hFFFF_FFFF, valid: 1'b1, yumi: 1'b1};
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (st !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", st); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (tm !== '0) begin errors++; $display("FAIL reset_to_mem got=%h exp=0", tm); end
        checks++; if ({maddr, ldata} !== 64'd0) begin errors++; $display("FAIL reset_regs got=%h/%h exp=0/0", maddr, ldata); end
        checks++; if ({done, err} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", done, err); end
        @(posedge clk); #1;
        mem_op  = 1'b0;
        fm      = '0;
        n_reset = 1'b1;
        last_load = '0;
    endtask

    // One complete access. ydly: request cycles before memory yumis;
    // vdly: for loads, further cycles before read data is valid.
    task automatic do_access(input logic ld, input logic by, input logic [31:0] a,
                             input logic [31:0] sd, input logic [31:0] rw,
                             input int ydly, input int vdly, input string tag);
        logic [31:0] exp_wd, exp_ld, sh;
        int          last;
        exp_wd = by ? (sd & 32'hFF) * 32'h0101_0101 : sd;
        sh     = rw >> (8 * int'(a[1:0]));
        exp_ld = ld ? (by ? (sh & 32'hFF) : rw) : last_load;
        last   = ld ? ydly + vdly : ydly;

        @(posedge clk); #1;
        mem_op = 1'b1; is_load = ld; is_byte = by; addr = a; sdata = sd; fm = '0;
        @(negedge clk);
        checks++; if ({stall, st} !== 3'b100) begin errors++; $display("FAIL %s accept got stall=%b st=%0d exp stall=1 st=0", tag, stall, st); end

        for (int k = 0; k <= last; k++) begin
            @(posedge clk); #1;
            fm.yumi      = (k == ydly);
            fm.valid     = ld && (k == last);
            fm.read_data = fm.valid ? rw : $urandom();
            @(negedge clk);
            checks++; if (st !== ((k <= ydly) ? 2'd1 : 2'd2)) begin errors++; $display("FAIL %s state k=%0d got=%0d exp=%0d", tag, k, st, (k <= ydly) ? 1 : 2); end
            checks++; if (tm.valid !== (k <= ydly)) begin errors++; $display("FAIL %s req_valid k=%0d got=%b exp=%b", tag, k, tm.valid, k <= ydly); end
            if (k <= ydly) begin
                checks++; if ({tm.wen, tm.byte_not_word} !== {~ld, by}) begin errors++; $display("FAIL %s wen_bnw got=%b%b exp=%b%b", tag, tm.wen, tm.byte_not_word, ~ld, by); end
                if (!ld) begin
                    checks++; if (tm.write_data !== exp_wd) begin errors++; $display("FAIL %s wdata got=%h exp=%h", tag, tm.write_data, exp_wd); end
                end
            end
            checks++; if (tm.yumi !== (ld && k == last)) begin errors++; $display("FAIL %s to_mem_yumi k=%0d got=%b exp=%b", tag, k, tm.yumi, ld && k == last); end
            checks++; if ({stall, done, err} !== 3'b100) begin errors++; $display("FAIL %s busy_flags k=%0d got=%b%b%b exp=100", tag, k, stall, done, err); end
            checks++; if (maddr !== a) begin errors++; $display("FAIL %s addr got=%h exp=%h", tag, maddr, a); end
        end

        // Done cycle: the retiring instruction is still presented.
        @(posedge clk); #1;
        fm = '{read_data: $urandom(), valid: 1'b0, yumi: 1'b0};
        @(negedge clk);
        checks++; if ({done, stall, st} !== 4'b1000) begin errors++; $display("FAIL %s done_cycle got done=%b stall=%b st=%0d exp 1,0,0", tag, done, stall, st); end
        checks++; if (ldata !== exp_ld) begin errors++; $display("FAIL %s load_data got=%h exp=%h", tag, ldata, exp_ld); end
        checks++; if (tm !== '0) begin errors++; $display("FAIL %s done_to_mem got=%h exp=0", tag, tm); end

        @(posedge clk); #1;
        mem_op = 1'b0;
        @(negedge clk);
        checks++; if ({done, stall, st} !== 4'b0000) begin errors++; $display("FAIL %s after_done got done=%b stall=%b st=%0d exp 0,0,0", tag, done, stall, st); end
        checks++; if (ldata !== exp_ld) begin errors++; $display("FAIL %s load_hold got=%h exp=%h", tag, ldata, exp_ld); end
        last_load = exp_ld;
    endtask

    task automatic test_directed();
        do_access(1'b0, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, 0, "sw");
        do_access(1'b1, 1'b1, 32'h13, 32'h0, 32'h1122_3344, 0, 0, "lbu");
        checks++; if (last_load !== 32'h0000_0011) begin errors++; $display("FAIL lbu_value got=%h exp=00000011", last_load); end
        do_access(1'b1, 1'b0, 32'h24, 32'h0, 32'hCAFE_F00D, 3, 4, "lw_slow");
        do_access(1'b0, 1'b1, 32'h31, 32'h0000_00A5, 32'h0, 0, 0, "sb");
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(),
                      $urandom(), $urandom(), $urandom_range(0, 4), $urandom_range(0, 4), "rand");
        end
    endtask

    task automatic test_timeout_edge();
        // Completion on the last permitted waiting cycle must still retire.
        do_access(1'b0, 1'b0, 32'h80, 32'h0BAD_CAFE, 32'h0, TMAX, 0, "to_edge_sw");
        do_access(1'b1, 1'b0, 32'h84, 32'h0, 32'h5566_7788, 5, TMAX - 5, "to_edge_lw");
    endtask

    task automatic test_idle_ignore();
        @(posedge clk); #1;
        mem_op = 1'b0;
        fm = '{read_data: 32'hA5A5_5A5A, valid: 1'b1, yumi: 1'b1};
        repeat (3) begin
            @(negedge clk);
            checks++; if ({tm.yumi, stall, done, st} !== 5'b00000) begin errors++; $display("FAIL idle_ignore got yumi=%b stall=%b done=%b st=%0d exp all 0", tm.yumi, stall, done, st); end
            @(posedge clk); #1;
        end
        fm = '0;
        checks++; if (ldata !== last_load) begin errors++; $display("FAIL idle_ignore_ldata got=%h exp=%h", ldata, last_load); end
    endtask

    task automatic test_back_to_back();
        logic        ld_q [2] = '{1'b1, 1'b0};
        logic [31:0] ad_q [2] = '{32'h100, 32'h104};
        int idx = 0, accepts = 0, dones = 0, reqs = 0, cyc = 0;
        while (dones < 2 && cyc < 40) begin
            @(posedge clk); #1;
            if (idx < 2) begin
                mem_op = 1'b1; is_load = ld_q[idx]; is_byte = 1'b0;
                addr = ad_q[idx]; sdata = 32'h7777_0000 + 32'(idx);
            end else begin
                mem_op = 1'b0;
            end
            // Memory accepts immediately and answers loads in the same cycle.
            fm.yumi = tm.valid;
            fm.valid = tm.valid && !tm.wen;
            fm.read_data = 32'h0F1E_2D3C;
            @(negedge clk);
            cyc++;
            if (stall && st == 2'd0) accepts++;
            if (tm.valid) reqs++;
            if (done) begin
                dones++;
                if (dones == 1) begin
                    checks++; if (ldata !== 32'h0F1E_2D3C) begin errors++; $display("FAIL b2b_lw_data got=%h exp=0f1e2d3c", ldata); end
                end
            end
            if (mem_op && !stall) idx++;
        end
        checks++; if (dones !== 2) begin errors++; $display("FAIL b2b_done_count got=%0d exp=2 (cycle budget %0d)", dones, cyc); end
        @(posedge clk); #1;
        mem_op = 1'b0; fm = '0;
        repeat (2) begin
            @(negedge clk);
            if (stall && st == 2'd0) accepts++;
            if (tm.valid) reqs++;
            @(posedge clk); #1;
        end
        checks++; if (accepts !== 2) begin errors++; $display("FAIL b2b_accepts got=%0d exp=2", accepts); end
        checks++; if (reqs !== 2) begin errors++; $display("FAIL b2b_requests got=%0d exp=2", reqs); end
        checks++; if (idx !== 2) begin errors++; $display("FAIL b2b_retired got=%0d exp=2", idx); end
        last_load = 32'h0F1E_2D3C;
    endtask

    task automatic test_timeout();
        @(posedge clk); #1;
        mem_op = 1'b1; is_load = 1'b0; is_byte = 1'b0; addr = 32'h200; sdata = 32'h1; fm = '0;
        @(posedge clk); #1;
        // Waiting cycles 0..TMAX stay in REQ_SENT; the next one is ERR.
        for (int k = 0; k <= TMAX + 1; k++) begin
            @(negedge clk);
            if (k <= TMAX) begin
                checks++; if ({err, st} !== 3'b001) begin errors++; $display("FAIL timeout_wait k=%0d got err=%b st=%0d exp 0,1", k, err, st); end
            end else begin
                checks++; if ({err, stall, st} !== 4'b1111) begin errors++; $display("FAIL timeout_err got err=%b stall=%b st=%0d exp 1,1,3", err, stall, st); end
                checks++; if (tm !== '0) begin errors++; $display("FAIL timeout_to_mem got=%h exp=0", tm); end
            end
            @(posedge clk); #1;
        end
        // Late responses do not rescue the access.
        fm = '{read_data: 32'h1, valid: 1'b1, yumi: 1'b1};
        mem_op = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++; if ({err, stall, done, tm.yumi, st} !== 6'b110011) begin errors++; $display("FAIL err_sticky got err=%b stall=%b done=%b yumi=%b st=%0d exp 1,1,0,0,3", err, stall, done, tm.yumi, st); end
            @(posedge clk); #1;
        end
        mem_op = 1'b1;
        #2 n_reset = 1'b0;
        #1;
        checks++; if ({err, stall, done, st} !== 5'b00000 || tm !== '0 || maddr !== '0 || ldata !== '0) begin
            errors++; $display("FAIL err_reset got err=%b stall=%b done=%b st=%0d to_mem=%h addr=%h ld=%h exp all 0", err, stall, done, st, tm, maddr, ldata);
        end
        @(posedge clk); #1;
        mem_op = 1'b0; fm = '0; n_reset = 1'b1;
        last_load = '0;
    endtask

    task automatic test_reset_mid_access();
        @(posedge clk); #1;
        mem_op = 1'b1; is_load = 1'b1; is_byte = 1'b0; addr = 32'h300; sdata = 32'h0; fm = '0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (st !== 2'd1) begin errors++; $display("FAIL mid_reset_setup got st=%0d exp=1", st); end
        #2 n_reset = 1'b0;
        #1;
        checks++; if ({stall, done, st} !== 4'b0000 || tm !== '0 || maddr !== '0) begin
            errors++; $display("FAIL mid_reset got stall=%b done=%b st=%0d to_mem=%h addr=%h exp all 0", stall, done, st, tm, maddr);
        end
        @(posedge clk); #1;
        mem_op = 1'b0; n_reset = 1'b1;
        fm = '{read_data: 32'hEEEE_EEEE, valid: 1'b1, yumi: 1'b1};
        repeat (3) begin
            @(negedge clk);
            checks++; if ({done, tm.yumi, st} !== 4'b0000) begin errors++; $display("FAIL abandoned got done=%b yumi=%b st=%0d exp 0,0,0", done, tm.yumi, st); end
            @(posedge clk); #1;
        end
        fm = '0;
        checks++; if (ldata !== 32'h0) begin errors++; $display("FAIL abandoned_ldata got=%h exp=0", ldata); end
        last_load = '0;
        do_access(1'b1, 1'b1, 32'h301, 32'h0, 32'h99AA_BBCC, 1, 1, "post_reset_lbu");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_idle_ignore();
        test_random();
        test_timeout_edge();
        test_back_to_back();
        test_timeout();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
